work_time_recorder: RTL

- Accumulates appliance working time as packed BCD HH:MM:SS on `record[23:0]`.
- Feeds `record_light` directly: `record` here drives its `record` input, and `power_now` is shared.
- Counts only while powered and the work load (motor/fan) is running. Holds its value across power-off.
- Clears on a user request and raises a maintenance reminder once accumulated hours pass a threshold.

---
 rtl/work_time_recorder_pkg.sv | 18 +
 rtl/bcd_pair_counter.sv | 52 +++++
 rtl/work_time_recorder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/work_time_recorder_pkg.sv
// Shared definitions for the working-time recorder and its display stage (record_light).
package work_time_recorder_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_STANDBY = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned RECORD_W   = 24;
    localparam logic [23:0] RECORD_MAX = 24'h995959;

    function automatic int unsigned bcd_pair_to_bin(input logic [7:0] pair);
        return 32'(pair[7:4]) * 10 + 32'(pair[3:0]);
    endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter: units 0-9, tens 0-TENS_MAX, carry out when an increment wraps the pair.
module bcd_pair_counter
    import work_time_recorder_pkg::*;
#(
    parameter int unsigned TENS_MAX = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    input  logic               hold,
    output logic [2*BCD_W-1:0] pair,
    output logic               carry_out
);

    logic [BCD_W-1:0] ones_q, ones_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic             adv;
    logic             at_max;

    always_comb begin
        adv       = inc && !hold;
        at_max    = (tens_q == BCD_W'(TENS_MAX)) && (ones_q == 4'd9);
        carry_out = adv && at_max;
        ones_d    = ones_q;
        tens_d    = tens_q;
        if (clr) begin
            ones_d = '0;
            tens_d = '0;
        end else if (adv) begin
            if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = at_max ? '0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign pair = {tens_q, ones_q};

endmodule

// File: rtl/work_time_recorder.sv
// Accumulates powered run time as BCD HH:MM:SS with saturation and a maintenance reminder.
// Define RECORD_FAST_SIM_EN to use SIM_DIV cycles per second instead of CLK_FREQ.
module work_time_recorder
    import work_time_recorder_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned REMIND_HOURS = 10,
    parameter int unsigned SIM_DIV      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                power_now,
    input  logic                work_en,
    input  logic                clear_req,
    output logic [RECORD_W-1:0] record,
    output logic                full,
    output logic                remind
);

`ifdef RECORD_FAST_SIM_EN
    localparam bit FAST_SIM = 1'b1;
`else
    localparam bit FAST_SIM = 1'b0;
`endif

    localparam int unsigned PRESC_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int unsigned TERM_CNT   = FAST_SIM ? SIM_DIV - 1 : CLK_FREQ - 1;
    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(TERM_CNT);

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 full_q, full_d;
    logic                 remind_q, remind_d;
    logic                 clr, run, tick, sat;
    logic [2*BCD_W-1:0]   sec, min, hr;
    logic                 sec_carry, min_carry, hr_carry;

    assign record = {hr, min, sec};

    always_comb begin
        state_d = ST_OFF;
        if (power_now) begin
            state_d = work_en ? ST_RUN : ST_STANDBY;
        end
    end

    always_comb begin
        clr  = clear_req && power_now;
        run  = (state_q == ST_RUN);
        tick = run && (presc_q == PRESC_TERM);
        sat  = (record == RECORD_MAX);

        // Leaving RUN discards the partial second.
        presc_d = presc_q + 1'b1;
        if (clr || !run || tick) begin
            presc_d = '0;
        end

        full_d = full_q;
        if (clr) begin
            full_d = 1'b0;
        end else if (tick && sat) begin
            full_d = 1'b1;
        end

        remind_d = (REMIND_HOURS != 0) && (bcd_pair_to_bin(hr) >= REMIND_HOURS);
    end

    bcd_pair_counter #(.TENS_MAX(5)) u_sec (
        .clk       (clk),
        .rst       (rst),
        .inc       (tick),
        .clr       (clr),
        .hold      (sat),
        .pair      (sec),
        .carry_out (sec_carry)
    );

    bcd_pair_counter #(.TENS_MAX(5)) u_min (
        .clk       (clk),
        .rst       (rst),
        .inc       (sec_carry),
        .clr       (clr),
        .hold      (sat),
        .pair      (min),
        .carry_out (min_carry)
    );

    // Hours never wrap: saturation holds every stage at 99:59:59.
    bcd_pair_counter #(.TENS_MAX(9)) u_hr (
        .clk       (clk),
        .rst       (rst),
        .inc       (min_carry),
        .clr       (clr),
        .hold      (sat),
        .pair      (hr),
        .carry_out (hr_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_OFF;
            presc_q  <= '0;
            full_q   <= 1'b0;
            remind_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            full_q   <= full_d;
            remind_q <= remind_d;
        end
    end

    assign full   = full_q;
    assign remind = remind_q;

    logic unused_carry;
    assign unused_carry = hr_carry;

endmodule
